butterfly: RTL and testbench

BUTTERFLY -- requirements
Module: butterfly

---
 rtl/butterfly_pkg.sv | 24 ++
 rtl/cmul.sv | 50 +++++
 rtl/butterfly.sv | 80 ++++++++
 tb/tb_butterfly.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/butterfly_pkg.sv
// Shared parameters and helpers for the radix-2 DIT butterfly.
// Saturation is written over a wide signed value so any component width fits.
package butterfly_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int CMD_WIDTH_DEF  = 3;
  localparam int TW_FRAC_DEF    = 14;
  localparam int SAT_W          = 64;

  // Clamp v into the signed range of a dw-bit two's complement value.
  function automatic logic signed [SAT_W-1:0] saturate(
    input logic signed [SAT_W-1:0] v,
    input int                      dw
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      saturate = hi;
    else if (v < lo) saturate = lo;
    else             saturate = v;
  endfunction

endpackage

// File: rtl/cmul.sv
// Complex multiply B*W: registered full-precision products,
// then combinational round-half-up back to data scale.
module cmul
  import butterfly_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TW_FRAC    = TW_FRAC_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [2*DATA_WIDTH-1:0]        b,
  input  logic [2*DATA_WIDTH-1:0]        w,
  output logic signed [2*DATA_WIDTH+1:0] p_re,
  output logic signed [2*DATA_WIDTH+1:0] p_im
);

  localparam int DW = DATA_WIDTH;
  localparam int PR = 2 * DW;
  localparam int PW = 2 * DW + 2;
  localparam logic signed [PW-1:0] HALF = PW'(1) << (TW_FRAC - 1);

  logic signed [DW-1:0] b_re, b_im, w_re, w_im;
  logic signed [PR-1:0] rr, ii, ri, ir;
  logic signed [PW-1:0] re_sum, im_sum;

  assign b_re = b[2*DW-1:DW];
  assign b_im = b[DW-1:0];
  assign w_re = w[2*DW-1:DW];
  assign w_im = w[DW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= '0;
      ii <= '0;
      ri <= '0;
      ir <= '0;
    end else begin
      rr <= b_re * w_re;
      ii <= b_im * w_im;
      ri <= b_re * w_im;
      ir <= b_im * w_re;
    end
  end

  assign re_sum = PW'(rr) - PW'(ii) + HALF;
  assign im_sum = PW'(ri) + PW'(ir) + HALF;
  assign p_re   = re_sum >>> TW_FRAC;
  assign p_im   = im_sum >>> TW_FRAC;

endmodule

// File: rtl/butterfly.sv
// Two-stage radix-2 DIT butterfly: out_a = A + B*W, out_b = A - B*W,
// saturated, with a command tag delayed alongside the data.
module butterfly
  import butterfly_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CMD_WIDTH  = CMD_WIDTH_DEF,
  parameter int TW_FRAC    = TW_FRAC_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2*DATA_WIDTH-1:0] in_a,
  input  logic [2*DATA_WIDTH-1:0] in_b,
  input  logic [2*DATA_WIDTH-1:0] w,
  input  logic [CMD_WIDTH-1:0]    m_in,
  output logic [2*DATA_WIDTH-1:0] out_a,
  output logic [2*DATA_WIDTH-1:0] out_b,
  output logic [CMD_WIDTH-1:0]    m_out
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DW + 2;
  localparam int SW = PW + 1;

  logic [2*DW-1:0]      a_q;
  logic [CMD_WIDTH-1:0] m_q;
  logic signed [PW-1:0] p_re, p_im;
  logic signed [DW-1:0] a_re, a_im;
  logic signed [SW-1:0] sum_re, sum_im, dif_re, dif_im;
  logic [DW-1:0]        oa_re, oa_im, ob_re, ob_im;

  cmul #(
    .DATA_WIDTH (DATA_WIDTH),
    .TW_FRAC    (TW_FRAC)
  ) u_cmul (
    .clk   (clk),
    .rst_n (rst_n),
    .b     (in_b),
    .w     (w),
    .p_re  (p_re),
    .p_im  (p_im)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      m_q <= '0;
    end else begin
      a_q <= in_a;
      m_q <= m_in;
    end
  end

  assign a_re = a_q[2*DW-1:DW];
  assign a_im = a_q[DW-1:0];

  always_comb begin
    sum_re = SW'(a_re) + SW'(p_re);
    sum_im = SW'(a_im) + SW'(p_im);
    dif_re = SW'(a_re) - SW'(p_re);
    dif_im = SW'(a_im) - SW'(p_im);
    oa_re  = DW'(saturate(SAT_W'(sum_re), DW));
    oa_im  = DW'(saturate(SAT_W'(sum_im), DW));
    ob_re  = DW'(saturate(SAT_W'(dif_re), DW));
    ob_im  = DW'(saturate(SAT_W'(dif_im), DW));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_a <= '0;
      out_b <= '0;
      m_out <= '0;
    end else begin
      out_a <= {oa_re, oa_im};
      out_b <= {ob_re, ob_im};
      m_out <= m_q;
    end
  end

endmodule

// File: tb/tb_butterfly.sv
// Directed self-checking bench for butterfly: latency, rounding,
// saturation, streaming and mid-stream reset.
module tb_butterfly;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_a, in_b, w;
  logic [2:0]  m_in;
  logic [31:0] out_a, out_b;
  logic [2:0]  m_out;

  int total;
  int passed;

  butterfly dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in_a  (in_a),
    .in_b  (in_b),
    .w     (w),
    .m_in  (m_in),
    .out_a (out_a),
    .out_b (out_b),
    .m_out (m_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input int re, input int im);
    logic [15:0] r;
    logic [15:0] i;
    r = re[15:0];
    i = im[15:0];
    return {r, i};
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] tw, input logic [2:0] m);
    in_a = a;
    in_b = b;
    w    = tw;
    m_in = m;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(pk(100, 200), pk(3, 4), pk(16384, 0), 3'd7);
    #3;
    total++;
    if (out_a !== 32'h0) $display("FAIL reset_out_a got %h want %h", out_a, 32'h0);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (out_b !== 32'h0) $display("FAIL reset_out_b got %h want %h", out_b, 32'h0);
    else passed++;
    total++;
    if (m_out !== 3'd0) $display("FAIL reset_m_out got %0d want 0", m_out);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_passthrough;
    @(negedge clk);
    drive(pk(16304, 0), pk(6384, -110), pk(16384, 0), 3'd1);
    @(posedge clk);
    #1;
    drive(32'h0, 32'h0, 32'h0, 3'd0);
    total++;
    if (m_out === 3'd1) $display("FAIL early_m_out got %0d want not 1", m_out);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (out_a !== pk(22688, -110))
      $display("FAIL pass_out_a got %h want %h", out_a, pk(22688, -110));
    else passed++;
    total++;
    if (out_b !== pk(9920, 110))
      $display("FAIL pass_out_b got %h want %h", out_b, pk(9920, 110));
    else passed++;
    total++;
    if (m_out !== 3'd1) $display("FAIL pass_m_out got %0d want 1", m_out);
    else passed++;
  endtask

  task automatic test_rounding;
    @(negedge clk);
    drive(pk(1634, -110), pk(1384, 0), pk(11585, -11585), 3'd2);
    @(posedge clk);
    @(posedge clk);
    #1;
    total++;
    if (out_a !== pk(2613, -1089))
      $display("FAIL round_out_a got %h want %h", out_a, pk(2613, -1089));
    else passed++;
    total++;
    if (out_b !== pk(655, 869))
      $display("FAIL round_out_b got %h want %h", out_b, pk(655, 869));
    else passed++;
    total++;
    if (m_out !== 3'd2) $display("FAIL round_m_out got %0d want 2", m_out);
    else passed++;
  endtask

  task automatic test_saturation;
    @(negedge clk);
    drive(pk(32767, -32768), pk(32767, 32767), pk(16384, 0), 3'd6);
    @(posedge clk);
    @(posedge clk);
    #1;
    total++;
    if (out_a !== pk(32767, -1))
      $display("FAIL sat_out_a got %h want %h", out_a, pk(32767, -1));
    else passed++;
    total++;
    if (out_b !== pk(0, -32768))
      $display("FAIL sat_out_b got %h want %h", out_b, pk(0, -32768));
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic [31:0] ea [5];
    logic [31:0] eb [5];
    va = '{pk(100, -1), pk(200, -2), pk(300, -3), pk(400, -4), pk(500, -5)};
    vb = '{pk(1, 10), pk(2, 10), pk(3, 10), pk(4, 10), pk(5, 10)};
    ea = '{pk(101, 9), pk(202, 8), pk(303, 7), pk(404, 6), pk(505, 5)};
    eb = '{pk(99, -11), pk(198, -12), pk(297, -13), pk(396, -14), pk(495, -15)};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        total++;
        if (out_a !== ea[i-2] || out_b !== eb[i-2])
          $display("FAIL b2b_data%0d got %h/%h want %h/%h",
                   i - 2, out_a, out_b, ea[i-2], eb[i-2]);
        else passed++;
        total++;
        if (m_out !== 3'(i - 1))
          $display("FAIL b2b_m%0d got %0d want %0d", i - 2, m_out, i - 1);
        else passed++;
      end
      if (i < 5) drive(va[i], vb[i], pk(16384, 0), 3'(i + 1));
      else       drive(32'h0, 32'h0, 32'h0, 3'd0);
    end
  endtask

  task automatic test_reset_midstream;
    @(negedge clk);
    drive(pk(1000, 0), pk(7, 7), pk(16384, 0), 3'd3);
    @(posedge clk);
    #1;
    drive(pk(2000, 0), pk(8, 8), pk(16384, 0), 3'd4);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_a !== 32'h0 || out_b !== 32'h0 || m_out !== 3'd0)
      $display("FAIL midrst_zero got %h/%h/%0d want 0/0/0", out_a, out_b, m_out);
    else passed++;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(pk(-500, 300), pk(20, -20), pk(16384, 0), 3'd5);
    @(posedge clk);
    #1;
    drive(32'h0, 32'h0, 32'h0, 3'd0);
    total++;
    if (out_a !== 32'h0 || m_out !== 3'd0)
      $display("FAIL midrst_flushed got %h/%0d want 0/0", out_a, m_out);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (out_a !== pk(-480, 280) || out_b !== pk(-520, 320))
      $display("FAIL midrst_data got %h/%h want %h/%h",
               out_a, out_b, pk(-480, 280), pk(-520, 320));
    else passed++;
    total++;
    if (m_out !== 3'd5) $display("FAIL midrst_m got %0d want 5", m_out);
    else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset;
    test_passthrough;
    test_rounding;
    test_saturation;
    test_back_to_back;
    test_reset_midstream;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
